multicycle_control_unit: RTL and testbench

//   FSM control unit for the multi-cycle RV32I core; supersedes the single-cycle controller.

---
 rtl/multicycle_control_unit_pkg.sv | 83 ++++++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit_alu_ctrl_decoder.sv | 39 +++
 rtl/multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
//   - FSM state codes (plain localparams so legacy code can compare raw values)
//   - RV32I major opcodes
//   - ALUControl encodings and the ALUOp class driving the ALU decoder
//   - datapath mux select codes and immediate-format selects
//   - branch_taken(): evaluates the branch condition from funct3 and the {V,C,Z,N} flags
package multicycle_control_unit_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_EXECU    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_e;

  localparam logic [3:0] ALUC_ADD  = 4'd0;
  localparam logic [3:0] ALUC_SUB  = 4'd1;
  localparam logic [3:0] ALUC_SLL  = 4'd2;
  localparam logic [3:0] ALUC_SLT  = 4'd3;
  localparam logic [3:0] ALUC_SLTU = 4'd4;
  localparam logic [3:0] ALUC_XOR  = 4'd5;
  localparam logic [3:0] ALUC_SRL  = 4'd6;
  localparam logic [3:0] ALUC_SRA  = 4'd7;
  localparam logic [3:0] ALUC_OR   = 4'd8;
  localparam logic [3:0] ALUC_AND  = 4'd9;

  localparam logic [1:0] RS_ALUOUT  = 2'd0;
  localparam logic [1:0] RS_MEM     = 2'd1;
  localparam logic [1:0] RS_ALU     = 2'd2;
  localparam logic [1:0] RS_TRAPVEC = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // flags = {V,C,Z,N}; C=1 means no borrow on rs1-rs2.
  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] flags);
    logic v, c, z, n, t;
    {v, c, z, n} = flags;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = n ^ v;
      3'b101:  t = !(n ^ v);
      3'b110:  t = !c;
      3'b111:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle.
//   master: control unit (reads IR fields, flags, mem_ready; drives all mux selects/enables)
//   slave : datapath/memory side
interface multicycle_control_unit_if;
  logic [6:0] OPCode;
  logic [2:0] funct3;
  logic       funct75;
  logic [3:0] ALUFlags;
  logic       mem_ready;
  logic       memReq;
  logic       memWrite;
  logic       adrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       regWrite;
  logic [1:0] resultSource;
  logic [1:0] srcAIn;
  logic [1:0] srcBIn;
  logic [2:0] immSource;
  logic [2:0] loadCtrl;
  logic [1:0] storeCtrl;
  logic [3:0] ALUControl;
  logic       trap;

  modport master (
    input  OPCode, funct3, funct75, ALUFlags, mem_ready,
    output memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, resultSource,
           srcAIn, srcBIn, immSource, loadCtrl, storeCtrl, ALUControl, trap
  );

  modport slave (
    output OPCode, funct3, funct75, ALUFlags, mem_ready,
    input  memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, resultSource,
           srcAIn, srcBIn, immSource, loadCtrl, storeCtrl, ALUControl, trap
  );
endinterface

// File: rtl/multicycle_control_unit_alu_ctrl_decoder.sv
// Combinational ALU operation decoder.
//   alu_op      in  ALUOp class: forced add, forced sub, or decode from funct
//   funct3      in  IR[14:12]
//   funct75     in  IR[30]
//   is_rtype    in  instruction is OP (register-register)
//   alu_control out ALUControl encoding
module multicycle_control_unit_alu_ctrl_decoder
  import multicycle_control_unit_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       is_rtype,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      default: begin
        case (funct3)
          // IR[30] is part of the immediate for ADDI, so only R-type may subtract
          3'b000:  alu_control = (is_rtype && funct75) ? ALUC_SUB : ALUC_ADD;
          3'b001:  alu_control = ALUC_SLL;
          3'b010:  alu_control = ALUC_SLT;
          3'b011:  alu_control = ALUC_SLTU;
          3'b100:  alu_control = ALUC_XOR;
          // SRAI/SRA both encode IR[30]=1
          3'b101:  alu_control = funct75 ? ALUC_SRA : ALUC_SRL;
          3'b110:  alu_control = ALUC_OR;
          default: alu_control = ALUC_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM.
//   clk, rst_n  core clock / asynchronous active-low reset
//   bus         multicycle_control_unit_if.master: IR fields, flags, mem handshake in;
//               every datapath mux select and enable out
//   instret     retired-instruction counter (INSTRET_W bits, wraps)
// Optional feature macro TRAP_EN: adds the TRAP state for illegal opcodes and a
// per-request memory wait timeout of TIMEOUT_CYC cycles. Without it, illegal
// opcodes retire as NOPs, waits are unbounded and trap stays 0.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned INSTRET_W   = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_unit_if.master bus,
  output logic [INSTRET_W-1:0]     instret
);

  logic [3:0]           state, state_nx;
  logic [INSTRET_W-1:0] instret_q;
  logic                 mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap_c;
  logic [1:0]           res_src, src_a, src_b;
  logic [2:0]           imm_src;
  logic [3:0]           alu_ctrl;
  aluop_e               alu_op;
  logic                 retire;

`ifdef TRAP_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WCNT_W-1:0] wait_cnt;
  logic              timeout;
  assign timeout = mem_req && !bus.mem_ready && (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    trap_c    = 1'b0;
    res_src   = RS_ALUOUT;
    src_a     = SRCA_PC;
    src_b     = SRCB_RS2;
    imm_src   = IMM_I;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RS_ALU;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut gets oldPC+imm as the speculative target; JAL needs the J format
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        imm_src = (bus.OPCode == OP_JAL) ? IMM_J : IMM_B;
        case (bus.OPCode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_OP:             state_nx = S_EXECR;
          OP_OPIMM:          state_nx = S_EXECI;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_LUI, OP_AUIPC:  state_nx = S_EXECU;
`ifdef TRAP_EN
          default:           state_nx = S_TRAP;
`else
          default:           state_nx = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        src_a    = SRCA_RS1;
        src_b    = SRCB_IMM;
        imm_src  = (bus.OPCode == OP_STORE) ? IMM_S : IMM_I;
        state_nx = (bus.OPCode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        res_src   = RS_MEM;
        state_nx  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (bus.mem_ready) state_nx = S_FETCH;
      end
      S_EXECR: begin
        src_a    = SRCA_RS1;
        alu_op   = ALUOP_FUNCT;
        state_nx = S_ALUWB;
      end
      S_EXECI: begin
        src_a    = SRCA_RS1;
        src_b    = SRCB_IMM;
        alu_op   = ALUOP_FUNCT;
        state_nx = S_ALUWB;
      end
      S_EXECU: begin
        src_a    = (bus.OPCode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        src_b    = SRCB_IMM;
        imm_src  = IMM_U;
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        // JALR left its target in ALUOut, so the link value is recomputed here
        if (bus.OPCode == OP_JALR) begin
          res_src = RS_ALU;
          src_a   = SRCA_OLDPC;
          src_b   = SRCB_FOUR;
        end
        state_nx = S_FETCH;
      end
      S_JAL: begin
        pc_write = 1'b1;
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        state_nx = S_ALUWB;
      end
      S_JALR: begin
        // datapath clears bit 0 of the RS_ALU path when loading PC
        pc_write = 1'b1;
        src_a    = SRCA_RS1;
        src_b    = SRCB_IMM;
        res_src  = RS_ALU;
        state_nx = S_JALR == state ? S_ALUWB : state;
      end
      S_BRANCH: begin
        src_a    = SRCA_RS1;
        imm_src  = IMM_B;
        alu_op   = ALUOP_SUB;
        pc_write = branch_taken(bus.funct3, bus.ALUFlags);
        state_nx = S_FETCH;
      end
`ifdef TRAP_EN
      S_TRAP: begin
        trap_c   = 1'b1;
        pc_write = 1'b1;
        res_src  = RS_TRAPVEC;
        state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_FETCH;
    endcase
`ifdef TRAP_EN
    if (timeout) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      state_nx = S_TRAP;
    end
`endif
  end

  multicycle_control_unit_alu_ctrl_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct75     (bus.funct75),
    .is_rtype    (bus.OPCode == OP_OP),
    .alu_control (alu_ctrl)
  );

  // Trap entries are not retirements
  assign retire = (state_nx == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      instret_q <= '0;
    end else begin
      state <= state_nx;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

`ifdef TRAP_EN
  // Counts consecutive unanswered request cycles; any other cycle clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wait_cnt <= '0;
    else if (mem_req && !bus.mem_ready && !timeout) wait_cnt <= wait_cnt + WCNT_W'(1);
    else                                        wait_cnt <= '0;
  end
`endif

  // Outputs are forced low while rst_n is asserted so an in-flight request
  // drops immediately rather than at the next edge.
  assign bus.memReq       = rst_n & mem_req;
  assign bus.memWrite     = rst_n & mem_write;
  assign bus.adrSrc       = rst_n & adr_src;
  assign bus.IRWrite      = rst_n & ir_write;
  assign bus.PCWrite      = rst_n & pc_write;
  assign bus.regWrite     = rst_n & reg_write;
  assign bus.trap         = rst_n & trap_c;
  assign bus.resultSource = rst_n ? res_src : 2'd0;
  assign bus.srcAIn       = rst_n ? src_a : 2'd0;
  assign bus.srcBIn       = rst_n ? src_b : 2'd0;
  assign bus.immSource    = rst_n ? imm_src : 3'd0;
  assign bus.loadCtrl     = rst_n ? bus.funct3 : 3'd0;
  assign bus.storeCtrl    = rst_n ? bus.funct3[1:0] : 2'd0;
  assign bus.ALUControl   = rst_n ? alu_ctrl : 4'd0;
  assign instret          = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam int IW = 4;
  localparam int TO = 5;

  // enable vector order: {memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, trap}
  localparam logic [6:0] E_NONE  = 7'b0000000;
  localparam logic [6:0] E_FWAIT = 7'b1000000;
  localparam logic [6:0] E_FETCH = 7'b1001100;
  localparam logic [6:0] E_MRD   = 7'b1010000;
  localparam logic [6:0] E_MWR   = 7'b1110000;
  localparam logic [6:0] E_PC    = 7'b0000100;
  localparam logic [6:0] E_RW    = 7'b0000010;
  localparam logic [6:0] E_TRAP  = 7'b0000101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] instret;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.INSTRET_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .instret (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic [3:0] fl;
    logic       rdy;
    logic [6:0] en;
    logic [1:0] rs, sa, sb;
    logic [3:0] aluc;
    logic       ret;
  } vec_t;

  typedef struct {
    string         name;
    logic [16:0]   ctl;
    logic [IW-1:0] ir;
  } exp_t;

  vec_t          tbl[$];
  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [IW-1:0] model_ir = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic logic [16:0] act_ctl();
    return {bus.memReq, bus.memWrite, bus.adrSrc, bus.IRWrite, bus.PCWrite, bus.regWrite,
            bus.trap, bus.resultSource, bus.srcAIn, bus.srcBIn, bus.ALUControl};
  endfunction

  task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic f75, input logic [3:0] fl, input logic rdy,
                     input logic [6:0] en, input logic [1:0] rs, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [3:0] aluc, input logic ret);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f75 = f75; v.fl = fl; v.rdy = rdy;
    v.en = en; v.rs = rs; v.sa = sa; v.sb = sb; v.aluc = aluc; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic fetch_dec(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic [3:0] fl);
    add({nm, ".fetch"}, op, f3, f75, fl, 1'b1, E_FETCH, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    add({nm, ".decode"}, op, f3, f75, fl, 1'b0, E_NONE, RS_ALUOUT, SRCA_OLDPC, SRCB_IMM, ALUC_ADD, 1'b0);
  endtask

  task automatic branch(input string nm, input logic [2:0] f3, input logic [3:0] fl, input logic taken);
    fetch_dec(nm, OP_BRANCH, f3, 1'b0, fl);
    add({nm, ".branch"}, OP_BRANCH, f3, 1'b0, fl, 1'b0, taken ? E_PC : E_NONE,
        RS_ALUOUT, SRCA_RS1, SRCB_RS2, ALUC_SUB, 1'b1);
  endtask

  task automatic alu_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic [3:0] aluc);
    fetch_dec(nm, op, f3, f75, 4'b0);
    add({nm, ".exec"}, op, f3, f75, 4'b0, 1'b1, E_NONE, RS_ALUOUT, SRCA_RS1,
        (op == OP_OP) ? SRCB_RS2 : SRCB_IMM, aluc, 1'b0);
    add({nm, ".aluwb"}, op, f3, f75, 4'b0, 1'b0, E_RW, RS_ALUOUT, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b1);
  endtask

  // Drive each row after the edge, queue its expectation, compare mid-cycle.
  task automatic run_tbl();
    exp_t e, h;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      bus.OPCode = tbl[i].op; bus.funct3 = tbl[i].f3; bus.funct75 = tbl[i].f75;
      bus.ALUFlags = tbl[i].fl; bus.mem_ready = tbl[i].rdy;
      e.name = tbl[i].name;
      e.ctl  = {tbl[i].en, tbl[i].rs, tbl[i].sa, tbl[i].sb, tbl[i].aluc};
      e.ir   = model_ir;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check("scoreboard.empty", 32'd0, 32'd1);
      end else begin
        h = sb_q.pop_front();
        check({h.name, ".ctl"}, 32'(act_ctl()), 32'(h.ctl));
        check({h.name, ".instret"}, 32'(instret), 32'(h.ir));
      end
      if (tbl[i].ret) model_ir = model_ir + 1'b1;
    end
    tbl.delete();
  endtask

  initial begin
    bus.OPCode = OP_JAL; bus.funct3 = 3'b0; bus.funct75 = 1'b0;
    bus.ALUFlags = 4'b0; bus.mem_ready = 1'b1;
    #12;
    check("reset.ctl", 32'(act_ctl()), 32'd0);
    check("reset.instret", 32'(instret), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;

    // main table
    add("fetch.wait", OP_OP, 3'b0, 1'b0, 4'b0, 1'b0, E_FWAIT, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    alu_instr("add",  OP_OP,    3'b000, 1'b0, ALUC_ADD);
    alu_instr("sub",  OP_OP,    3'b000, 1'b1, ALUC_SUB);
    alu_instr("srai", OP_OPIMM, 3'b101, 1'b1, ALUC_SRA);
    alu_instr("addi", OP_OPIMM, 3'b000, 1'b1, ALUC_ADD);
    alu_instr("xor",  OP_OP,    3'b100, 1'b0, ALUC_XOR);
    fetch_dec("lw", OP_LOAD, 3'b010, 1'b0, 4'b0);
    add("lw.memadr", OP_LOAD, 3'b010, 1'b0, 4'b0, 1'b1, E_NONE, RS_ALUOUT, SRCA_RS1, SRCB_IMM, ALUC_ADD, 1'b0);
    for (int k = 0; k < 4; k++)
      add("lw.memread", OP_LOAD, 3'b010, 1'b0, 4'b0, (k == 3), E_MRD, RS_ALUOUT, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b0);
    add("lw.memwb", OP_LOAD, 3'b010, 1'b0, 4'b0, 1'b0, E_RW, RS_MEM, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b1);
    branch("blt",   3'b100, 4'b0001, 1'b1);
    branch("bgeu",  3'b111, 4'b0000, 1'b0);
    branch("beq",   3'b000, 4'b0010, 1'b1);
    branch("f3010", 3'b010, 4'b0010, 1'b0);
    branch("bge",   3'b101, 4'b1001, 1'b1);
    fetch_dec("jal", OP_JAL, 3'b0, 1'b0, 4'b0);
    add("jal.jump", OP_JAL, 3'b0, 1'b0, 4'b0, 1'b0, E_PC, RS_ALUOUT, SRCA_OLDPC, SRCB_FOUR, ALUC_ADD, 1'b0);
    add("jal.aluwb", OP_JAL, 3'b0, 1'b0, 4'b0, 1'b0, E_RW, RS_ALUOUT, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b1);
    fetch_dec("jalr", OP_JALR, 3'b0, 1'b0, 4'b0);
    add("jalr.jump", OP_JALR, 3'b0, 1'b0, 4'b0, 1'b0, E_PC, RS_ALU, SRCA_RS1, SRCB_IMM, ALUC_ADD, 1'b0);
    add("jalr.aluwb", OP_JALR, 3'b0, 1'b0, 4'b0, 1'b0, E_RW, RS_ALU, SRCA_OLDPC, SRCB_FOUR, ALUC_ADD, 1'b1);
    fetch_dec("lui", OP_LUI, 3'b0, 1'b0, 4'b0);
    add("lui.execu", OP_LUI, 3'b0, 1'b0, 4'b0, 1'b0, E_NONE, RS_ALUOUT, SRCA_ZERO, SRCB_IMM, ALUC_ADD, 1'b0);
    add("lui.aluwb", OP_LUI, 3'b0, 1'b0, 4'b0, 1'b0, E_RW, RS_ALUOUT, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b1);
    fetch_dec("auipc", OP_AUIPC, 3'b0, 1'b0, 4'b0);
    add("auipc.execu", OP_AUIPC, 3'b0, 1'b0, 4'b0, 1'b0, E_NONE, RS_ALUOUT, SRCA_OLDPC, SRCB_IMM, ALUC_ADD, 1'b0);
    add("auipc.aluwb", OP_AUIPC, 3'b0, 1'b0, 4'b0, 1'b0, E_RW, RS_ALUOUT, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b1);
`ifndef TRAP_EN
    add("nop.fetch", 7'h00, 3'b0, 1'b0, 4'b0, 1'b1, E_FETCH, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    add("nop.decode", 7'h00, 3'b0, 1'b0, 4'b0, 1'b0, E_NONE, RS_ALUOUT, SRCA_OLDPC, SRCB_IMM, ALUC_ADD, 1'b1);
`endif
    add("post.fetch", OP_OP, 3'b0, 1'b0, 4'b0, 1'b0, E_FWAIT, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    run_tbl();

    // store stalled in MEMWRITE, then asynchronous reset mid-request
    fetch_dec("sw", OP_STORE, 3'b010, 1'b0, 4'b0);
    add("sw.memadr", OP_STORE, 3'b010, 1'b0, 4'b0, 1'b0, E_NONE, RS_ALUOUT, SRCA_RS1, SRCB_IMM, ALUC_ADD, 1'b0);
    add("sw.memwrite", OP_STORE, 3'b010, 1'b0, 4'b0, 1'b0, E_MWR, RS_ALUOUT, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b0);
    run_tbl();
    check("sw.storectrl", 32'(bus.storeCtrl), 32'd2);
    @(posedge clk); #2;
    check("sw.held", 32'(act_ctl()), 32'({E_MWR, 10'b0}));
    rst_n = 1'b0;
    #1;
    check("rst.async.ctl", 32'(act_ctl()), 32'd0);
    check("rst.async.instret", 32'(instret), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ir = '0;

    // 16 retirements wrap a 4-bit counter back to zero
    for (int k = 0; k < 16; k++) branch("wrap", 3'b000, 4'b0000, 1'b0);
    add("wrap.fetch", OP_OP, 3'b0, 1'b0, 4'b0, 1'b0, E_FWAIT, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    run_tbl();
    check("wrap.zero", 32'(instret), 32'd0);

`ifdef TRAP_EN
    add("ill.fetch", 7'h00, 3'b0, 1'b0, 4'b0, 1'b1, E_FETCH, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    add("ill.decode", 7'h00, 3'b0, 1'b0, 4'b0, 1'b0, E_NONE, RS_ALUOUT, SRCA_OLDPC, SRCB_IMM, ALUC_ADD, 1'b0);
    add("ill.trap", 7'h00, 3'b0, 1'b0, 4'b0, 1'b0, E_TRAP, RS_TRAPVEC, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b0);
    for (int k = 0; k < TO; k++)
      add("to.wait", OP_OP, 3'b0, 1'b0, 4'b0, 1'b0, E_FWAIT, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    add("to.trap", OP_OP, 3'b0, 1'b0, 4'b0, 1'b0, E_TRAP, RS_TRAPVEC, SRCA_PC, SRCB_RS2, ALUC_ADD, 1'b0);
    add("to.fetch", OP_OP, 3'b0, 1'b0, 4'b0, 1'b0, E_FWAIT, RS_ALU, SRCA_PC, SRCB_FOUR, ALUC_ADD, 1'b0);
    run_tbl();
`endif

    if (sb_q.size() != 0) check("scoreboard.leftover", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
